// File: rtl/fp_issue_sequencer.sv
// FP issue sequencer: registers one FP op, drives the FP32 execution unit until done
// (or watchdog), then holds the response until the writeback stage consumes it.
module fp_issue_sequencer #(
  parameter int unsigned TAG_WIDTH      = 5,
  parameter int unsigned TIMEOUT_CYCLES = 63  // legal range 1..255
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic [2:0]           frm_i,
  // Issue side
  input  logic                 reqValid_i,
  output logic                 reqReady_o,
  input  logic [TAG_WIDTH-1:0] reqTag_i,
  input  logic [2:0]           reqUnit_i,        // FpUnitType
  input  logic [3:0]           reqCommand_i,     // FpUnitCommand
  input  logic [2:0]           reqRoundingMode_i,
  input  logic [31:0]          reqIntSrc1_i,
  input  logic [31:0]          reqIntSrc2_i,
  input  logic [31:0]          reqFpSrc1_i,
  input  logic [31:0]          reqFpSrc2_i,
  input  logic [31:0]          reqFpSrc3_i,
  // Execution unit side
  output logic                 fpuEnable_o,
  output logic                 fpuFlush_o,
  output logic [2:0]           fpuUnit_o,
  output logic [3:0]           fpuCommand_o,
  output logic [2:0]           fpuRoundingMode_o,
  output logic [31:0]          fpuIntSrc1_o,
  output logic [31:0]          fpuIntSrc2_o,
  output logic [31:0]          fpuFpSrc1_o,
  output logic [31:0]          fpuFpSrc2_o,
  output logic [31:0]          fpuFpSrc3_o,
  input  logic [31:0]          fpuIntResult_i,
  input  logic [31:0]          fpuFpResult_i,
  input  logic                 fpuWriteFlags_i,
  input  logic [4:0]           fpuFlagsValue_i,  // fflags_t
  input  logic                 fpuDone_i,
  // Writeback side
  output logic                 rspValid_o,
  input  logic                 rspReady_i,
  output logic [TAG_WIDTH-1:0] rspTag_o,
  output logic [31:0]          rspIntResult_o,
  output logic [31:0]          rspFpResult_o,
  output logic                 rspWriteFlags_o,
  output logic [4:0]           rspFlags_o,
  output logic                 rspIllegal_o,
  output logic                 rspTimeout_o
);

  typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 load_req;
  logic [2:0]           rm_res;

  logic [TAG_WIDTH-1:0] tag_q;
  logic [2:0]           unit_q;
  logic [3:0]           cmd_q;
  logic [2:0]           rm_q;
  logic [31:0]          isrc1_q, isrc2_q, fsrc1_q, fsrc2_q, fsrc3_q;

  logic [31:0]          rsp_int_q, rsp_int_d;
  logic [31:0]          rsp_fp_q, rsp_fp_d;
  logic                 rsp_wf_q, rsp_wf_d;
  logic [4:0]           rsp_flags_q, rsp_flags_d;
  logic                 rsp_illegal_q, rsp_illegal_d;
  logic                 rsp_timeout_q, rsp_timeout_d;

  // rm=3'b111 selects the dynamic rounding mode from fcsr.frm
  assign rm_res = (reqRoundingMode_i == 3'b111) ? frm_i : reqRoundingMode_i;

  // Next-state, watchdog counter and response capture
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    load_req      = 1'b0;
    rsp_int_d     = rsp_int_q;
    rsp_fp_d      = rsp_fp_q;
    rsp_wf_d      = rsp_wf_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_illegal_d = rsp_illegal_q;
    rsp_timeout_d = rsp_timeout_q;
    if (flush_i) begin
      // Flush overrides everything, including a same-cycle request or rspReady
      state_d       = StIdle;
      rsp_illegal_d = 1'b0;
      rsp_timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (reqValid_i) begin
            load_req = 1'b1;
            if (rm_res >= 3'd5) begin
              // Reserved rounding mode: report without ever enabling the unit
              state_d       = StHold;
              rsp_int_d     = '0;
              rsp_fp_d      = '0;
              rsp_wf_d      = 1'b0;
              rsp_flags_d   = '0;
              rsp_illegal_d = 1'b1;
              rsp_timeout_d = 1'b0;
            end else begin
              state_d = StExec;
              cnt_d   = '0;
            end
          end
        end
        StExec: begin
          cnt_d = cnt_q + 8'd1;
          if (fpuDone_i) begin
            state_d       = StHold;
            rsp_int_d     = fpuIntResult_i;
            rsp_fp_d      = fpuFpResult_i;
            rsp_wf_d      = fpuWriteFlags_i;
            rsp_flags_d   = fpuFlagsValue_i;
            rsp_illegal_d = 1'b0;
            rsp_timeout_d = 1'b0;
          end else if (cnt_q == TimeoutLast) begin
            state_d       = StHold;
            rsp_int_d     = '0;
            rsp_fp_d      = '0;
            rsp_wf_d      = 1'b0;
            rsp_flags_d   = '0;
            rsp_illegal_d = 1'b0;
            rsp_timeout_d = 1'b1;
          end
        end
        StHold: begin
          if (rspReady_i) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State, counter and response registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      rsp_int_q     <= '0;
      rsp_fp_q      <= '0;
      rsp_wf_q      <= 1'b0;
      rsp_flags_q   <= '0;
      rsp_illegal_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rsp_int_q     <= rsp_int_d;
      rsp_fp_q      <= rsp_fp_d;
      rsp_wf_q      <= rsp_wf_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_illegal_q <= rsp_illegal_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Operand registers: loaded only on accept, so they hold through EXEC and afterwards
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q   <= '0;
      unit_q  <= '0;
      cmd_q   <= '0;
      rm_q    <= '0;
      isrc1_q <= '0;
      isrc2_q <= '0;
      fsrc1_q <= '0;
      fsrc2_q <= '0;
      fsrc3_q <= '0;
    end else if (load_req) begin
      tag_q   <= reqTag_i;
      unit_q  <= reqUnit_i;
      cmd_q   <= reqCommand_i;
      rm_q    <= rm_res;
      isrc1_q <= reqIntSrc1_i;
      isrc2_q <= reqIntSrc2_i;
      fsrc1_q <= reqFpSrc1_i;
      fsrc2_q <= reqFpSrc2_i;
      fsrc3_q <= reqFpSrc3_i;
    end
  end

  assign reqReady_o        = (state_q == StIdle) && rst_ni;
  assign fpuEnable_o       = (state_q == StExec);
  assign fpuFlush_o        = flush_i;
  assign fpuUnit_o         = unit_q;
  assign fpuCommand_o      = cmd_q;
  assign fpuRoundingMode_o = rm_q;
  assign fpuIntSrc1_o      = isrc1_q;
  assign fpuIntSrc2_o      = isrc2_q;
  assign fpuFpSrc1_o       = fsrc1_q;
  assign fpuFpSrc2_o       = fsrc2_q;
  assign fpuFpSrc3_o       = fsrc3_q;

  assign rspValid_o      = (state_q == StHold);
  assign rspTag_o        = tag_q;
  assign rspIntResult_o  = rsp_int_q;
  assign rspFpResult_o   = rsp_fp_q;
  assign rspWriteFlags_o = rsp_wf_q;
  assign rspFlags_o      = rsp_flags_q;
  assign rspIllegal_o    = rsp_illegal_q;
  assign rspTimeout_o    = rsp_timeout_q;

endmodule

// File: tb/tb_fp_issue_sequencer.sv
// Bench for fp_issue_sequencer: table of ops run against a long-timeout instance (a) and a
// TIMEOUT_CYCLES=4 instance (b), plus hand sequences for flush and async reset.
module tb_fp_issue_sequencer;

  localparam int unsigned TW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, reqValid, rspReady, fpuDone, fpuWriteFlags;
  logic [2:0]    frm, reqUnit, reqRoundingMode;
  logic [3:0]    reqCommand;
  logic [TW-1:0] reqTag;
  logic [31:0]   reqIntSrc1, reqIntSrc2, reqFpSrc1, reqFpSrc2, reqFpSrc3;
  logic [31:0]   fpuIntResult, fpuFpResult;
  logic [4:0]    fpuFlagsValue;

  // Per-instance outputs
  logic          a_reqReady, a_fpuEnable, a_fpuFlush, a_rspValid, a_rspWriteFlags;
  logic          a_rspIllegal, a_rspTimeout;
  logic [2:0]    a_fpuUnit, a_fpuRoundingMode;
  logic [3:0]    a_fpuCommand;
  logic [31:0]   a_fpuIntSrc1, a_fpuIntSrc2, a_fpuFpSrc1, a_fpuFpSrc2, a_fpuFpSrc3;
  logic [31:0]   a_rspIntResult, a_rspFpResult;
  logic [TW-1:0] a_rspTag;
  logic [4:0]    a_rspFlags;
  logic          b_reqReady, b_fpuEnable, b_fpuFlush, b_rspValid, b_rspWriteFlags;
  logic          b_rspIllegal, b_rspTimeout;
  logic [2:0]    b_fpuUnit, b_fpuRoundingMode;
  logic [3:0]    b_fpuCommand;
  logic [31:0]   b_fpuIntSrc1, b_fpuIntSrc2, b_fpuFpSrc1, b_fpuFpSrc2, b_fpuFpSrc3;
  logic [31:0]   b_rspIntResult, b_rspFpResult;
  logic [TW-1:0] b_rspTag;
  logic [4:0]    b_rspFlags;

  // Selected instance view
  logic          sel;
  logic          o_reqReady, o_fpuEnable, o_fpuFlush, o_rspValid, o_rspWriteFlags;
  logic          o_rspIllegal, o_rspTimeout;
  logic [2:0]    o_fpuUnit, o_fpuRoundingMode;
  logic [31:0]   o_fpuIntSrc1, o_fpuFpSrc1, o_rspIntResult, o_rspFpResult;
  logic [TW-1:0] o_rspTag;
  logic [4:0]    o_rspFlags;

  always_comb begin
    if (sel) begin
      o_reqReady = b_reqReady;   o_fpuEnable = b_fpuEnable;   o_fpuFlush = b_fpuFlush;
      o_rspValid = b_rspValid;   o_rspWriteFlags = b_rspWriteFlags;
      o_rspIllegal = b_rspIllegal; o_rspTimeout = b_rspTimeout;
      o_fpuUnit = b_fpuUnit;     o_fpuRoundingMode = b_fpuRoundingMode;
      o_fpuIntSrc1 = b_fpuIntSrc1; o_fpuFpSrc1 = b_fpuFpSrc1;
      o_rspIntResult = b_rspIntResult; o_rspFpResult = b_rspFpResult;
      o_rspTag = b_rspTag;       o_rspFlags = b_rspFlags;
    end else begin
      o_reqReady = a_reqReady;   o_fpuEnable = a_fpuEnable;   o_fpuFlush = a_fpuFlush;
      o_rspValid = a_rspValid;   o_rspWriteFlags = a_rspWriteFlags;
      o_rspIllegal = a_rspIllegal; o_rspTimeout = a_rspTimeout;
      o_fpuUnit = a_fpuUnit;     o_fpuRoundingMode = a_fpuRoundingMode;
      o_fpuIntSrc1 = a_fpuIntSrc1; o_fpuFpSrc1 = a_fpuFpSrc1;
      o_rspIntResult = a_rspIntResult; o_rspFpResult = a_rspFpResult;
      o_rspTag = a_rspTag;       o_rspFlags = a_rspFlags;
    end
  end

  fp_issue_sequencer #(.TAG_WIDTH(TW), .TIMEOUT_CYCLES(63)) u_dut_a (
    .clk_i(clk), .rst_ni(rst), .flush_i(flush), .frm_i(frm),
    .reqValid_i(reqValid), .reqReady_o(a_reqReady), .reqTag_i(reqTag), .reqUnit_i(reqUnit),
    .reqCommand_i(reqCommand), .reqRoundingMode_i(reqRoundingMode),
    .reqIntSrc1_i(reqIntSrc1), .reqIntSrc2_i(reqIntSrc2),
    .reqFpSrc1_i(reqFpSrc1), .reqFpSrc2_i(reqFpSrc2), .reqFpSrc3_i(reqFpSrc3),
    .fpuEnable_o(a_fpuEnable), .fpuFlush_o(a_fpuFlush), .fpuUnit_o(a_fpuUnit),
    .fpuCommand_o(a_fpuCommand), .fpuRoundingMode_o(a_fpuRoundingMode),
    .fpuIntSrc1_o(a_fpuIntSrc1), .fpuIntSrc2_o(a_fpuIntSrc2),
    .fpuFpSrc1_o(a_fpuFpSrc1), .fpuFpSrc2_o(a_fpuFpSrc2), .fpuFpSrc3_o(a_fpuFpSrc3),
    .fpuIntResult_i(fpuIntResult), .fpuFpResult_i(fpuFpResult),
    .fpuWriteFlags_i(fpuWriteFlags), .fpuFlagsValue_i(fpuFlagsValue), .fpuDone_i(fpuDone),
    .rspValid_o(a_rspValid), .rspReady_i(rspReady), .rspTag_o(a_rspTag),
    .rspIntResult_o(a_rspIntResult), .rspFpResult_o(a_rspFpResult),
    .rspWriteFlags_o(a_rspWriteFlags), .rspFlags_o(a_rspFlags),
    .rspIllegal_o(a_rspIllegal), .rspTimeout_o(a_rspTimeout)
  );

  fp_issue_sequencer #(.TAG_WIDTH(TW), .TIMEOUT_CYCLES(4)) u_dut_b (
    .clk_i(clk), .rst_ni(rst), .flush_i(flush), .frm_i(frm),
    .reqValid_i(reqValid), .reqReady_o(b_reqReady), .reqTag_i(reqTag), .reqUnit_i(reqUnit),
    .reqCommand_i(reqCommand), .reqRoundingMode_i(reqRoundingMode),
    .reqIntSrc1_i(reqIntSrc1), .reqIntSrc2_i(reqIntSrc2),
    .reqFpSrc1_i(reqFpSrc1), .reqFpSrc2_i(reqFpSrc2), .reqFpSrc3_i(reqFpSrc3),
    .fpuEnable_o(b_fpuEnable), .fpuFlush_o(b_fpuFlush), .fpuUnit_o(b_fpuUnit),
    .fpuCommand_o(b_fpuCommand), .fpuRoundingMode_o(b_fpuRoundingMode),
    .fpuIntSrc1_o(b_fpuIntSrc1), .fpuIntSrc2_o(b_fpuIntSrc2),
    .fpuFpSrc1_o(b_fpuFpSrc1), .fpuFpSrc2_o(b_fpuFpSrc2), .fpuFpSrc3_o(b_fpuFpSrc3),
    .fpuIntResult_i(fpuIntResult), .fpuFpResult_i(fpuFpResult),
    .fpuWriteFlags_i(fpuWriteFlags), .fpuFlagsValue_i(fpuFlagsValue), .fpuDone_i(fpuDone),
    .rspValid_o(b_rspValid), .rspReady_i(rspReady), .rspTag_o(b_rspTag),
    .rspIntResult_o(b_rspIntResult), .rspFpResult_o(b_rspFpResult),
    .rspWriteFlags_o(b_rspWriteFlags), .rspFlags_o(b_rspFlags),
    .rspIllegal_o(b_rspIllegal), .rspTimeout_o(b_rspTimeout)
  );

  typedef struct {
    logic        use_t;       // 1: check the TIMEOUT_CYCLES=4 instance
    logic [4:0]  tag;
    logic [2:0]  unit;
    logic [3:0]  cmd;
    logic [2:0]  rm;
    logic [2:0]  frm;
    logic [31:0] isrc1;
    logic [31:0] fsrc1;
    int          done_at;     // EXEC cycle with fpuDone=1, 0 = never
    logic [31:0] int_res;
    logic [31:0] fp_res;
    logic        wf;
    logic [4:0]  flags;
    int          ready_delay; // HOLD cycles before rspReady
    logic [2:0]  exp_rm;
    logic        exp_illegal;
    logic        exp_timeout;
    int          exp_exec;    // EXEC cycles expected
  } vec_t;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] int_res;
    logic [31:0] fp_res;
    logic        wf;
    logic [4:0]  flags;
    logic        illegal;
    logic        timeout;
  } rsp_t;

  vec_t tbl[10];
  rsp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reqValid = 1'b0; rspReady = 1'b0; fpuDone = 1'b0; flush = 1'b0;
  endtask

  task automatic drive_req(input logic [4:0] tag, input logic [2:0] unit, input logic [3:0] cmd,
                           input logic [2:0] rm, input logic [2:0] f, input logic [31:0] is1,
                           input logic [31:0] fs1);
    reqValid = 1'b1; reqTag = tag; reqUnit = unit; reqCommand = cmd;
    reqRoundingMode = rm; frm = f; reqIntSrc1 = is1; reqIntSrc2 = ~is1;
    reqFpSrc1 = fs1; reqFpSrc2 = fs1 ^ 32'h1; reqFpSrc3 = fs1 ^ 32'h2;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    rsp_t  e;
    string p;
    p = $sformatf("v%0d_", idx);
    sel = v.use_t;
    flush = 1'b1; step(); flush = 1'b0;
    drive_req(v.tag, v.unit, v.cmd, v.rm, v.frm, v.isrc1, v.fsrc1);
    #1;
    chk({p, "req_ready"}, 32'(o_reqReady), 32'd1);
    e.tag     = v.tag;
    e.illegal = v.exp_illegal;
    e.timeout = v.exp_timeout;
    e.int_res = (v.exp_illegal || v.exp_timeout) ? 32'h0 : v.int_res;
    e.fp_res  = (v.exp_illegal || v.exp_timeout) ? 32'h0 : v.fp_res;
    e.wf      = (v.exp_illegal || v.exp_timeout) ? 1'b0 : v.wf;
    e.flags   = (v.exp_illegal || v.exp_timeout) ? 5'h0 : v.flags;
    sb.push_back(e);
    step();
    // Scramble request inputs so any passthrough instead of latching shows up
    reqValid = 1'b0; reqFpSrc1 = ~v.fsrc1; reqIntSrc1 = ~v.isrc1;
    reqRoundingMode = 3'd0; frm = 3'd0;
    for (int k = 1; k <= v.exp_exec; k++) begin
      chk({p, "fpu_enable"}, 32'(o_fpuEnable), 32'd1);
      chk({p, "fpu_rm"}, 32'(o_fpuRoundingMode), 32'(v.exp_rm));
      chk({p, "fpu_fpsrc1"}, o_fpuFpSrc1, v.fsrc1);
      chk({p, "fpu_intsrc1"}, o_fpuIntSrc1, v.isrc1);
      chk({p, "fpu_unit"}, 32'(o_fpuUnit), 32'(v.unit));
      chk({p, "exec_rsp_valid"}, 32'(o_rspValid), 32'd0);
      chk({p, "exec_req_ready"}, 32'(o_reqReady), 32'd0);
      fpuDone = (k == v.done_at);
      fpuIntResult  = fpuDone ? v.int_res : (32'hDEAD0000 | 32'(k));
      fpuFpResult   = fpuDone ? v.fp_res : (32'hBEEF0000 | 32'(k));
      fpuWriteFlags = fpuDone ? v.wf : 1'b1;
      fpuFlagsValue = fpuDone ? v.flags : 5'h1F;
      step();
    end
    fpuDone = 1'b1; fpuIntResult = 32'hBAD0BAD0; fpuFpResult = 32'h0BAD0BAD;
    fpuWriteFlags = ~v.wf; fpuFlagsValue = ~v.flags;
    chk({p, "rsp_valid"}, 32'(o_rspValid), 32'd1);
    chk({p, "hold_enable"}, 32'(o_fpuEnable), 32'd0);
    if (o_rspValid && sb.size() > 0) begin
      e = sb.pop_front();
      for (int r = 0; r <= v.ready_delay; r++) begin
        chk({p, "hold_valid"}, 32'(o_rspValid), 32'd1);
        chk({p, "hold_req_ready"}, 32'(o_reqReady), 32'd0);
        chk({p, "rsp_tag"}, 32'(o_rspTag), 32'(e.tag));
        chk({p, "rsp_int"}, o_rspIntResult, e.int_res);
        chk({p, "rsp_fp"}, o_rspFpResult, e.fp_res);
        chk({p, "rsp_wf"}, 32'(o_rspWriteFlags), 32'(e.wf));
        chk({p, "rsp_flags"}, 32'(o_rspFlags), 32'(e.flags));
        chk({p, "rsp_illegal"}, 32'(o_rspIllegal), 32'(e.illegal));
        chk({p, "rsp_timeout"}, 32'(o_rspTimeout), 32'(e.timeout));
        if (r == v.ready_delay) rspReady = 1'b1;
        step();
      end
    end else begin
      sb.delete();
      rspReady = 1'b1;
      step();
    end
    rspReady = 1'b0; fpuDone = 1'b0;
    chk({p, "rsp_consumed"}, 32'(o_rspValid), 32'd0);
    chk({p, "ready_again"}, 32'(o_reqReady), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //        use tag unit cmd rm frm isrc1         fsrc1         done int_res       fp_res
    //        wf flags rdy exp_rm ill to exec
    tbl[0] = '{0, 9, 0, 0, 0, 0, 32'h0, 32'h3F800000, 1, 32'h3F800000, 32'h0,
               0, 5'h00, 0, 0, 0, 0, 1};
    tbl[1] = '{0, 3, 3, 2, 1, 0, 32'h0, 32'h40800000, 12, 32'h0, 32'h40000000,
               1, 5'h01, 3, 1, 0, 0, 12};
    tbl[2] = '{0, 4, 1, 1, 7, 3, 32'h12345678, 32'h3F000000, 2, 32'h0, 32'h3F800000,
               1, 5'h04, 0, 3, 0, 0, 2};
    tbl[3] = '{0, 5, 2, 3, 7, 5, 32'h1, 32'h2, 1, 32'hAAAA, 32'hBBBB,
               1, 5'h1F, 1, 0, 1, 0, 0};
    tbl[4] = '{0, 6, 2, 3, 6, 0, 32'h1, 32'h2, 1, 32'hAAAA, 32'hBBBB,
               1, 5'h1F, 0, 0, 1, 0, 0};
    tbl[5] = '{0, 7, 1, 5, 4, 2, 32'hCAFEF00D, 32'hBF800000, 3, 32'h1, 32'h3F800000,
               1, 5'h10, 2, 4, 0, 0, 3};
    tbl[6] = '{1, 10, 3, 2, 0, 0, 32'h0, 32'h40000000, 0, 32'h7, 32'h8,
               1, 5'h1F, 0, 0, 0, 1, 4};
    tbl[7] = '{1, 11, 3, 2, 2, 0, 32'h0, 32'h40000000, 4, 32'h11112222, 32'h33334444,
               1, 5'h02, 1, 2, 0, 0, 4};
    tbl[8] = '{1, 12, 3, 2, 3, 0, 32'h0, 32'h40000000, 5, 32'h5, 32'h6,
               1, 5'h03, 0, 3, 0, 1, 4};
    tbl[9] = '{1, 31, 0, 0, 7, 1, 32'hFFFFFFFF, 32'h0, 1, 32'h0, 32'h12345678,
               0, 5'h00, 0, 1, 0, 0, 1};

    sel = 1'b0;
    rst = 1'b0;
    idle_inputs();
    drive_req(5'd1, 3'd1, 4'd1, 3'd0, 3'd0, 32'h1, 32'h2);
    fpuIntResult = '0; fpuFpResult = '0; fpuWriteFlags = 1'b0; fpuFlagsValue = '0;
    repeat (2) step();
    // Reset state, with a request pending
    chk("rst_req_ready", 32'(a_reqReady), 32'd0);
    chk("rst_req_ready_b", 32'(b_reqReady), 32'd0);
    chk("rst_enable", 32'(a_fpuEnable), 32'd0);
    chk("rst_rsp_valid", 32'(a_rspValid), 32'd0);
    chk("rst_rsp_tag", 32'(a_rspTag), 32'd0);
    chk("rst_fpsrc1", a_fpuFpSrc1, 32'd0);
    chk("rst_illegal", 32'(a_rspIllegal), 32'd0);
    reqValid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();

    for (int i = 0; i < 10; i++) run_vec(i, tbl[i]);

    // Flush during EXEC cycle 2 of a sqrt
    sel = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    drive_req(5'd2, 3'd3, 4'd2, 3'd0, 3'd0, 32'h0, 32'h41100000);
    step();
    reqValid = 1'b0;
    chk("fl_exec1_enable", 32'(o_fpuEnable), 32'd1);
    step();
    flush = 1'b1;
    #1;
    chk("fl_fpu_flush", 32'(o_fpuFlush), 32'd1);
    chk("fl_exec2_enable", 32'(o_fpuEnable), 32'd1);
    step();
    flush = 1'b0;
    chk("fl_enable_off", 32'(o_fpuEnable), 32'd0);
    chk("fl_req_ready", 32'(o_reqReady), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("fl_no_rsp", 32'(o_rspValid), 32'd0);
      step();
    end

    // Flush together with reqValid in IDLE: not accepted
    drive_req(5'd3, 3'd0, 4'd0, 3'd0, 3'd0, 32'h0, 32'h1);
    flush = 1'b1;
    step();
    reqValid = 1'b0; flush = 1'b0;
    chk("flreq_enable", 32'(o_fpuEnable), 32'd0);
    chk("flreq_rsp_valid", 32'(o_rspValid), 32'd0);
    chk("flreq_ready", 32'(o_reqReady), 32'd1);

    // Flush with rspReady in HOLD: flush wins, illegal flag cleared
    drive_req(5'd4, 3'd0, 4'd0, 3'd5, 3'd0, 32'h0, 32'h1);
    step();
    reqValid = 1'b0;
    chk("flhold_valid", 32'(o_rspValid), 32'd1);
    chk("flhold_illegal", 32'(o_rspIllegal), 32'd1);
    flush = 1'b1; rspReady = 1'b1;
    step();
    flush = 1'b0; rspReady = 1'b0;
    chk("flhold_valid_off", 32'(o_rspValid), 32'd0);
    chk("flhold_illegal_off", 32'(o_rspIllegal), 32'd0);
    chk("flhold_ready", 32'(o_reqReady), 32'd1);

    // Asynchronous reset while holding a response
    drive_req(5'd8, 3'd0, 4'd0, 3'd0, 3'd0, 32'h0, 32'h3F800000);
    step();
    reqValid = 1'b0;
    fpuDone = 1'b1; fpuIntResult = 32'h55AA55AA;
    step();
    fpuDone = 1'b0;
    chk("ar_hold_valid", 32'(o_rspValid), 32'd1);
    chk("ar_hold_int", o_rspIntResult, 32'h55AA55AA);
    #2 rst = 1'b0;
    #1;
    chk("ar_valid", 32'(o_rspValid), 32'd0);
    chk("ar_enable", 32'(o_fpuEnable), 32'd0);
    chk("ar_int", o_rspIntResult, 32'd0);
    chk("ar_tag", 32'(o_rspTag), 32'd0);
    chk("ar_ready", 32'(o_reqReady), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    run_vec(10, tbl[0]);
    run_vec(11, tbl[7]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_issue_sequencer.md
Name: fp_issue_sequencer

Overview:
- Sits directly upstream of the FP32 execution unit, between the FP issue slot and the writeback/CSR stage.
- Accepts one FP operation per valid/ready handshake and registers its operands.
- Resolves dynamic rounding mode, holds unit inputs stable while `enable` is high, and waits for `done`, which covers multi-cycle sqrt.
- Captures result and flags, presents them downstream with valid/ready, and enforces flush and a watchdog timeout.

Parameters:
- TAG_WIDTH, 5: width of the op tag passed through unchanged.
- TIMEOUT_CYCLES, 63: max cycles in EXEC before forced completion. Legal range 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  squash in-flight op.
- frm  in  3  fcsr.frm dynamic rounding mode.
- reqValid  in  1  request valid.
- reqReady  out  1  request accepted when reqValid && reqReady.
- reqTag  in  TAG_WIDTH  op tag.
- reqUnit  in  FpUnitType  target sub-unit.
- reqCommand  in  FpUnitCommand  sub-unit command.
- reqRoundingMode  in  3  instruction rm field.
- reqIntSrc1, reqIntSrc2  in  32 each  integer operands.
- reqFpSrc1, reqFpSrc2, reqFpSrc3  in  32 each  FP operands.
- fpuEnable  out  1  op active in execution unit.
- fpuFlush  out  1  flush to execution unit.
- fpuUnit, fpuCommand, fpuRoundingMode(3), fpuIntSrc1/2(32), fpuFpSrc1/2/3(32)  out  registered operands.
- fpuIntResult, fpuFpResult  in  32 each  unit results.
- fpuWriteFlags  in  1  unit flag write enable.
- fpuFlagsValue  in  fflags_t(5)  unit flags.
- fpuDone  in  1  unit done.
- rspValid  out  1  response valid.
- rspReady  in  1  response consumed.
- rspTag  out  TAG_WIDTH  tag of completed op.
- rspIntResult, rspFpResult  out  32 each  results.
- rspWriteFlags  out  1  flag write enable.
- rspFlags  out  5  flags.
- rspIllegal  out  1  illegal rounding mode.
- rspTimeout  out  1  watchdog fired.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - All registered outputs and the counter are 0.
  - reqReady=0 while rst=0.
  - fpuEnable=0 and rspValid=0.
- FSM states: IDLE, EXEC, HOLD.
- reqReady = (state==IDLE) && rst. No accept in EXEC or HOLD. Max throughput is one op per 3 cycles.
- IDLE:
  - On reqValid && !flush, latch tag, unit, command and operands.
  - Resolve rm: if reqRoundingMode==3'b111 use frm, else use reqRoundingMode.
  - If the resolved rm is in {5,6,7}, go to HOLD with rspIllegal=1, results/flags/rspWriteFlags=0, and fpuEnable never asserted.
  - Otherwise go to EXEC with counter=0.
- EXEC:
  - fpuEnable=1, decoded from state.
  - fpu* operand outputs are driven from the latched registers and stay stable for the whole state.
  - Counter increments each cycle.
  - If fpuDone=1, capture fpuIntResult, fpuFpResult, fpuWriteFlags and fpuFlagsValue into rsp* registers, set rspIllegal=0 and rspTimeout=0, and go to HOLD.
  - Else if counter==TIMEOUT_CYCLES-1, go to HOLD with rspTimeout=1, results and flags 0, rspWriteFlags=0.
  - fpuDone wins over timeout in the same cycle.
- HOLD:
  - rspValid=1. rsp* outputs stay stable until accepted.
  - On rspReady, go to IDLE. The next request can be accepted in the following cycle.
- Latency: accept at cycle N, EXEC at N+1. A single-cycle unit gives rspValid at N+2. A unit with done after k EXEC cycles gives rspValid at N+1+k.
- fpuDone is ignored outside EXEC. fpu* operand outputs hold their last value when not in EXEC.
- Flush:
  - fpuFlush = flush, combinational.
  - In any state, flush=1 sends the FSM to IDLE next cycle.
  - Flush clears rspValid, rspIllegal and rspTimeout, and no response is produced.
  - Flush in HOLD together with rspReady: flush wins, with the same result.
  - Flush together with reqValid in IDLE: the request is not accepted.
- Reset asserted mid-operation: immediate return to IDLE, all outputs cleared, no response.

Test Plan:
- Move op: reqUnit=Move, reqFpSrc1=32'h3F800000, rm=0, fpuDone tied 1 → fpuEnable high exactly 1 cycle; rspValid at N+2; rspIntResult=32'h3F800000; rspTag echoes 5'd9.
- Sqrt with fpuDone at the 12th EXEC cycle, rspReady held 0 for 3 cycles → fpuFpSrc1 stable for 12 cycles; rspValid stays 1 with stable data until rspReady; reqReady=0 throughout.
- Dynamic rm: reqRoundingMode=7 with frm=3 → fpuRoundingMode=3. With frm=5 → no fpuEnable, rspIllegal=1, rspWriteFlags=0.
- Timeout: TIMEOUT_CYCLES=4, fpuDone never 1 → rspValid after exactly 4 EXEC cycles, rspTimeout=1. fpuDone=1 on the 4th EXEC cycle → rspTimeout=0 and results captured.
- Flush during EXEC cycle 2 of a sqrt → fpuFlush=1 that cycle; IDLE next cycle; no rspValid; reqReady=1.
- Reset: drop rst asynchronously during HOLD → rspValid and fpuEnable go 0 immediately; after release, a fresh op completes normally.
